// File: rtl/param_sp_ram_pkg.sv
// Shared types and constants for the parametrised single-port RAM.
package param_sp_ram_pkg;

    localparam int unsigned BYTE_W = 8;

    // ST_CLEAR: post-reset zero sweep; ST_READY: serving requests
    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_READY = 1'b1
    } state_e;

endpackage

// File: rtl/sp_ram_core.sv
// Storage array for param_sp_ram: byte-enable write port, registered read port.
// The array has no reset so it can map onto block RAM; only the read register
// resets.
// Ports:
//   clk_i, rst_n_i : clock, async active-low reset (read register only)
//   we_i, be_i     : write enable and per-byte write enables
//   addr_i         : shared word address
//   wdata_i        : write data
//   re_i           : read enable; loads rdata_o at the rising edge
//   rd_zero_i      : with re_i, loads zero instead of the array word
//   rdata_o        : registered read data, holds between reads
module sp_ram_core
    import param_sp_ram_pkg::*;
#(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned DEPTH  = 128,
    parameter int unsigned ADDR_W = $clog2(DEPTH)
) (
    input  logic                     clk_i,
    input  logic                     rst_n_i,
    input  logic                     we_i,
    input  logic [DATA_W/BYTE_W-1:0] be_i,
    input  logic [ADDR_W-1:0]        addr_i,
    input  logic [DATA_W-1:0]        wdata_i,
    input  logic                     re_i,
    input  logic                     rd_zero_i,
    output logic [DATA_W-1:0]        rdata_o
);

    localparam int unsigned NB = DATA_W / BYTE_W;

    logic [DATA_W-1:0] mem [DEPTH];

    // Byte-lane write; callers guarantee addr_i < DEPTH when we_i is set
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            for (int n = 0; n < NB; n++) begin
                if (be_i[n]) begin
                    mem[addr_i][n*BYTE_W +: BYTE_W] <= wdata_i[n*BYTE_W +: BYTE_W];
                end
            end
        end
    end

    // Synchronous read register
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            rdata_o <= '0;
        end else if (re_i) begin
            rdata_o <= rd_zero_i ? '0 : mem[addr_i];
        end
    end

endmodule

// File: rtl/param_sp_ram.sv
// Parametrised single-port synchronous RAM with byte enables, req/ready
// handshake, 1- or 2-cycle read pipeline and optional post-reset clear sweep.
// Ports:
//   clk_i, rst_n_i       : clock, async active-low reset
//   req_i, we_i          : request valid, 1 = write / 0 = read
//   addr_i, be_i, wdata_i: word address, byte enables, write data
//   ready_o              : request accepted when req_i && ready_o
//   rvalid_o, rdata_o    : read-data pulse and data (data holds between reads)
//   init_done_o          : clear sweep complete
module param_sp_ram
    import param_sp_ram_pkg::*;
#(
    parameter int unsigned DATA_W         = 32,
    parameter int unsigned DEPTH          = 128,
    parameter int unsigned ADDR_W         = $clog2(DEPTH),
    parameter int unsigned READ_LAT       = 1,
    parameter bit          CLEAR_ON_RESET = 1'b1
) (
    input  logic                     clk_i,
    input  logic                     rst_n_i,
    input  logic                     req_i,
    input  logic                     we_i,
    input  logic [ADDR_W-1:0]        addr_i,
    input  logic [DATA_W/BYTE_W-1:0] be_i,
    input  logic [DATA_W-1:0]        wdata_i,
    output logic                     ready_o,
    output logic                     rvalid_o,
    output logic [DATA_W-1:0]        rdata_o,
    output logic                     init_done_o
);

    localparam int unsigned        NB       = DATA_W / BYTE_W;
    localparam logic [ADDR_W:0]    DEPTH_V  = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W-1:0]  LAST_ADR = ADDR_W'(DEPTH - 1);

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   cnt_q, cnt_d;

    logic                acc;
    logic                in_range;
    logic                clearing;
    logic                mem_we;
    logic [ADDR_W-1:0]   mem_addr;
    logic [NB-1:0]       mem_be;
    logic [DATA_W-1:0]   mem_wdata;
    logic                rd_en;
    logic [DATA_W-1:0]   core_rdata;

    // State and clear-counter registers
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= CLEAR_ON_RESET ? ST_CLEAR : ST_READY;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next state: sweep every address once, then serve requests until reset
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_CLEAR: begin
                cnt_d = cnt_q + ADDR_W'(1);
                if (cnt_q == LAST_ADR) begin
                    state_d = ST_READY;
                    cnt_d   = '0;
                end
            end
            default: ;
        endcase
    end

    // Handshake outputs follow the state being entered
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            ready_o     <= 1'b0;
            init_done_o <= 1'b0;
        end else begin
            ready_o     <= (state_d == ST_READY);
            init_done_o <= (state_d == ST_READY);
        end
    end

    assign acc      = req_i & ready_o;
    assign in_range = ({1'b0, addr_i} < DEPTH_V);
    assign clearing = (state_q == ST_CLEAR);

    // Clear path owns the array during the sweep; user path otherwise
    assign mem_we    = clearing | (acc & we_i & in_range);
    assign mem_addr  = clearing ? cnt_q : addr_i;
    assign mem_be    = clearing ? '1    : be_i;
    assign mem_wdata = clearing ? '0    : wdata_i;
    assign rd_en     = acc & ~we_i;

    sp_ram_core #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_core (
        .clk_i     (clk_i),
        .rst_n_i   (rst_n_i),
        .we_i      (mem_we),
        .be_i      (mem_be),
        .addr_i    (mem_addr),
        .wdata_i   (mem_wdata),
        .re_i      (rd_en),
        .rd_zero_i (~in_range),
        .rdata_o   (core_rdata)
    );

    // Read pipeline: the core read register is the first stage
    if (READ_LAT == 1) begin : g_lat1
        always_ff @(posedge clk_i or negedge rst_n_i) begin
            if (!rst_n_i) begin
                rvalid_o <= 1'b0;
            end else begin
                rvalid_o <= rd_en;
            end
        end
        assign rdata_o = core_rdata;
    end else begin : g_lat2
        logic v1_q;
        always_ff @(posedge clk_i or negedge rst_n_i) begin
            if (!rst_n_i) begin
                v1_q     <= 1'b0;
                rvalid_o <= 1'b0;
                rdata_o  <= '0;
            end else begin
                v1_q     <= rd_en;
                rvalid_o <= v1_q;
                if (v1_q) begin
                    rdata_o <= core_rdata;
                end
            end
        end
    end

endmodule

// File: doc/param_sp_ram.md
# param_sp_ram

Parametrised single-port synchronous RAM, the successor to the 8-bit/128-entry single-port RAM. It adds:
- configurable data width and depth
- per-byte write enables
- a req/ready request handshake with a 1- or 2-cycle registered read pipeline
- an optional post-reset hardware clear sweep

It sits behind bus-side controllers as local scratch storage. Read and write data are separate unidirectional ports; there is no tri-state bus.

## Interface
Parameters:
- DATA_W, 32, data width in bits; must be a multiple of 8
- DEPTH, 128, number of words; any value ≥ 2, need not be a power of 2
- ADDR_W, $clog2(DEPTH), address width (derived; do not override)
- READ_LAT, 1, read latency in cycles; legal values 1 or 2
- CLEAR_ON_RESET, 1, when 1 every word is zeroed after reset release

Ports:
- clk_i  in  1  clock; all logic on the rising edge
- rst_n_i  in  1  reset, asynchronous and active-low
- req_i  in  1  request valid
- we_i  in  1  1 = write, 0 = read; qualified by req_i
- addr_i  in  ADDR_W  word address
- be_i  in  DATA_W/8  byte write enables; bit n covers wdata_i[8n+7:8n]
- wdata_i  in  DATA_W  write data
- ready_o  out  1  block accepts a request this cycle
- rvalid_o  out  1  single-cycle pulse; rdata_o is valid
- rdata_o  out  DATA_W  read data; holds its value between reads
- init_done_o  out  1  clear sweep complete; stays high until the next reset

## Operation
- State machine states: ST_CLEAR and ST_READY.
- Reset values: state = ST_CLEAR when CLEAR_ON_RESET = 1, otherwise ST_READY. All outputs reset to 0: ready_o, rvalid_o, rdata_o, init_done_o. The clear counter resets to 0.
- ST_CLEAR:
  - Writes all-zero to address cnt each cycle, then increments cnt.
  - After writing DEPTH-1, moves to ST_READY and sets init_done_o.
  - ready_o = 0 throughout; req_i is ignored, not queued.
- ST_READY: ready_o = 1 and init_done_o = 1, whatever CLEAR_ON_RESET is set to. There is no exit except reset.
- Accept condition: req_i && ready_o at a rising edge. One operation per cycle; back-to-back requests are accepted every cycle.
- Write:
  - For each n with be_i[n] = 1, byte n of mem[addr_i] is replaced.
  - be_i = 0 leaves memory unchanged.
  - No rvalid_o pulse.
- Read: returns mem[addr_i] with all bytes; be_i is ignored.
- Write-then-read of the same address on consecutive accepts returns the newly written data.
- Out-of-range address (addr_i ≥ DEPTH, only possible when DEPTH is not a power of 2):
  - a write is dropped;
  - a read still pulses rvalid_o, with rdata_o = 0.
- Memory contents are not affected by reset itself. When CLEAR_ON_RESET = 0, contents after power-up are undefined.

## Timing
- Read accepted at edge k:
  - READ_LAT = 1: rvalid_o and rdata_o update at edge k; rvalid_o is high for the cycle between edges k and k+1.
  - READ_LAT = 2: the same happens one edge later (edge k+1).
- Read pipeline is fully pipelined: N consecutive accepted reads give N consecutive rvalid_o pulses, in order.
- Write accepted at edge k is committed at edge k. A read accepted at edge k+1 sees it.
- Clear sweep (edges counted from the first rising edge after rst_n_i rises = edge 1):
  - zero-writes happen at edges 1..DEPTH;
  - ready_o and init_done_o go high after edge DEPTH;
  - the first request can be accepted at edge DEPTH+1.
- Reset asserted mid-sweep or mid-read:
  - all outputs clear immediately (asynchronously);
  - the in-flight read pipeline is discarded, with no late rvalid_o;
  - the sweep restarts from address 0 after release.
- ready_o never drops in ST_READY; there is no backpressure on rvalid_o.

## Structure
- Package param_sp_ram_pkg holds:
  - state enum state_e {ST_CLEAR, ST_READY};
  - localparam BYTE_W = 8.
- Sub-module sp_ram_core holds the storage array only:
  - byte-enable write port and synchronous read port;
  - no reset on the array, so it maps to block RAM.
- The top level holds the FSM, the clear counter, address range check, request muxing between the clear path and the user path, and the READ_LAT pipeline with its valid shift register.

## Test plan
- DATA_W=32, DEPTH=128, CLEAR_ON_RESET=1, READ_LAT=1: release reset, then read addresses 0, 64 and 127 → ready_o rises after edge 128; each read returns 0x00000000.
- Write 0x11223344 to addr 0x04 with be=4'hF, then write 0xAABBCCDD to 0x04 with be=4'b0101, then read 0x04 → rdata 0x11BB33DD.
- READ_LAT=2: write 0x45 to addr 0x4 and 0x22 to addr 0x5, then issue back-to-back reads of 0x4, 0x5, 0x4 → three consecutive rvalid_o pulses, the first after the second edge following the first accept, with data 0x45, 0x22, 0x45.
- DEPTH=100: write 0xDEADBEEF to addr 100, then read addr 100 and addr 99 → addr 100 returns 0; addr 99 is unchanged (0 after clear).
- Assert rst_n_i at sweep cycle 50, then release → every output is 0 during reset; after release, ready_o rises after edge DEPTH counted from the new release.
- Assert rst_n_i one cycle after a read is accepted → no rvalid_o pulse appears after release.
